// File: rtl/alu_pkg.sv
// Shared types for the ALU output stages: status flag bundle and a
// default-width result entry.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    typedef struct packed {
        logic carry;
        logic neg;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] z;
        alu_flags_t           flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_stage_flag_gen.sv
// Combinational status flag generator for an ALU result; reused by other
// ALU stages, so it carries its own WIDTH parameter.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_carry,
    output alu_flags_t       flags
);

    always_comb begin
        flags.carry = in_carry;
        flags.neg   = in_z[WIDTH-1];
        flags.zero  = ~|in_z;
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flags computed at capture, 2-entry skid buffer
// so in_ready comes straight from a flop, and a wrapping transfer counter.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, in_ready=1
// ONE   | head valid, skid free, in_ready=1
// FULL  | head and skid valid, in_ready=0
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_z,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic [WIDTH-1:0] head_z;
    logic [WIDTH-1:0] skid_z;
    alu_flags_t       head_flags;
    alu_flags_t       skid_flags;
    alu_flags_t       new_flags;
    logic             push;
    logic             pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .in_z     (in_z),
        .in_carry (in_carry),
        .flags    (new_flags)
    );

    // out_valid decodes the occupancy flop, so an async reset clears it at once
    assign out_valid = (occ != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_z     = head_z;
    assign out_carry = head_flags.carry;
    assign out_zero  = head_flags.zero;
    assign out_neg   = head_flags.neg;

    always_comb begin
        occ_next = occ;
        case (occ)
            EMPTY: if (push) occ_next = ONE;
            ONE: begin
                if (push && !pop)      occ_next = FULL;
                else if (pop && !push) occ_next = EMPTY;
            end
            FULL:  if (pop) occ_next = ONE;
            default: occ_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= EMPTY;
            in_ready <= 1'b1;
            xfer_cnt <= '0;
        end else begin
            occ      <= occ_next;
            in_ready <= (occ_next != FULL);
            if (pop) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_z     <= '0;
            head_flags <= '0;
            skid_z     <= '0;
            skid_flags <= '0;
        end else begin
            if ((occ == EMPTY && push) || (occ == ONE && push && pop)) begin
                head_z     <= in_z;
                head_flags <= new_flags;
            end else if (occ == FULL && pop) begin
                head_z     <= skid_z;
                head_flags <= skid_flags;
            end
            if (occ == ONE && push && !pop) begin
                skid_z     <= in_z;
                skid_flags <= new_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed phases plus random
// traffic, compared against a queue-based reference of the stage.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_z;
    logic       in_carry;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_z;
    logic       out_carry;
    logic       out_zero;
    logic       out_neg;
    logic [7:0] xfer_cnt;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // reference: FIFO of {carry, z}, pop count, and expected in_ready
    logic [4:0] mq[$];
    int         m_cnt;
    bit         m_ready;

    alu_result_stage #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_z      (in_z),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string ph);
        logic [4:0] e;
        int         ez;
        chk({ph, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({ph, ".in_ready"}, 32'(in_ready), 32'(m_ready));
        chk({ph, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt % 256));
        if (mq.size() != 0) begin
            e  = mq[0];
            ez = int'(e[3:0]);
            chk({ph, ".out_z"}, 32'(out_z), 32'(ez));
            chk({ph, ".out_carry"}, 32'(out_carry), 32'(e[4]));
            chk({ph, ".out_zero"}, 32'(out_zero), 32'(ez == 0));
            chk({ph, ".out_neg"}, 32'(out_neg), 32'(ez >= 8));
        end
    endtask

    task automatic step(input string ph);
        bit do_push;
        bit do_pop;
        do_push = in_valid && m_ready;
        do_pop  = (mq.size() != 0) && out_ready;
        @(posedge clk);
        #1;
        if (do_pop) begin
            void'(mq.pop_front());
            m_cnt++;
        end
        if (do_push) mq.push_back({in_carry, in_z});
        m_ready = (mq.size() < 2);
        check_state(ph);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        mq.delete();
        m_cnt    = 0;
        m_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_z      = 4'hF;
        in_carry  = 1'b1;
        out_ready = 1'b1;
        mq.delete();
        m_cnt   = 0;
        m_ready = 1'b1;

        // reset held with an active input
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        step("post_rst");

        // single transfer of a zero result with carry
        in_valid = 1'b1; in_z = 4'h0; in_carry = 1'b1; out_ready = 1'b1;
        step("single");
        chk("single.zero_flag", 32'(out_zero), 32'd1);
        in_valid = 1'b0;
        step("single_pop");
        chk("single.xfer1", 32'(xfer_cnt), 32'd1);

        // backpressure: fill the buffer and offer a third value
        out_ready = 1'b0;
        in_valid = 1'b1; in_z = 4'h9; in_carry = 1'b0;
        step("bp1");
        in_z = 4'hA;
        step("bp2");
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        in_z = 4'hB;
        repeat (3) step("bp_hold");
        chk("bp.head_9", 32'(out_z), 32'h9);
        chk("bp.neg", 32'(out_neg), 32'd1);

        // drain from FULL
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step("drain1");
        chk("drain.second_A", 32'(out_z), 32'hA);
        chk("drain.ready_back", 32'(in_ready), 32'd1);
        step("drain2");
        chk("drain.empty", 32'(out_valid), 32'd0);

        // streaming 0..F with push and pop every cycle
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_z     = 4'(i);
            in_carry = 1'($urandom_range(1));
            step("stream");
        end
        in_valid = 1'b0;
        step("stream_tail");
        chk("stream.xfer16", 32'(xfer_cnt), 32'd16);

        // asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_z = 4'h3;
        step("mid_fill1");
        in_z = 4'h5;
        step("mid_fill2");
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.in_ready", 32'(in_ready), 32'd1);
        chk("async_rst.xfer_cnt", 32'(xfer_cnt), 32'd0);
        mq.delete();
        m_cnt   = 0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("after_async_rst");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(1));
            in_z      = 4'($urandom_range(15));
            in_carry  = 1'($urandom_range(1));
            out_ready = ($urandom_range(3) != 0);
            step("rand");
        end

        // counter wrap: 257 transfers from reset
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_valid = 1'b1;
            in_z     = 4'($urandom_range(15));
            in_carry = 1'($urandom_range(1));
            step("wrap");
        end
        in_valid = 1'b0;
        step("wrap_tail");
        chk("wrap.xfer1", 32'(xfer_cnt), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
